// File: rtl/search_pkg.sv
// Shared definitions for the binary-search converter datapath and its consumers.
package search_pkg;
    localparam int SEARCH_DATA_W    = 8;
    localparam int SEARCH_FRAME_LEN = 8;

    typedef logic [SEARCH_DATA_W-1:0] search_res_t;
endpackage

// File: rtl/search_avg_window.sv
// Sliding window over the last 2^LOG2_DEPTH converter results: ring buffer,
// write pointer, fill counter and running sum, with a one-cycle "window full" update pulse.
module search_avg_window
    import search_pkg::*;
#(
    parameter int DATA_W     = SEARCH_DATA_W,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              res_in,
    input  logic                           res_stb,
    output logic [DATA_W+LOG2_DEPTH-1:0]   sum,
    output logic                           upd
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);

    logic [DATA_W-1:0]     ring_reg [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_reg;
    logic [LOG2_DEPTH:0]   fill_reg;
    logic [LOG2_DEPTH:0]   fill_next;
    logic [SUM_W-1:0]      sum_reg;
    logic [SUM_W-1:0]      sum_next;
    logic [DATA_W-1:0]     oldest;
    logic                  upd_reg;

    // Entries are cleared on reset so the evicted value reads as 0 during warm-up.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ring
        always_ff @(posedge clk) begin
            if (rst) begin
                ring_reg[gi] <= '0;
            end else if (res_stb && (wr_ptr_reg == LOG2_DEPTH'(gi))) begin
                ring_reg[gi] <= res_in;
            end
        end
    end

    always_comb begin
        oldest    = ring_reg[wr_ptr_reg];
        fill_next = (fill_reg == FULL) ? fill_reg : fill_reg + 1'b1;
        // Modular arithmetic: the true result always fits in SUM_W bits.
        sum_next  = sum_reg + SUM_W'(res_in) - SUM_W'(oldest);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            fill_reg   <= '0;
            sum_reg    <= '0;
            upd_reg    <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            if (res_stb) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                fill_reg   <= fill_next;
                sum_reg    <= sum_next;
                upd_reg    <= (fill_next == FULL);
            end
        end
    end

    assign sum = sum_reg;
    assign upd = upd_reg;
endmodule

// File: rtl/search_result_filter.sv
// Windowed truncated mean of converter results with valid/ready output and sticky overrun.
// Optional running min/max tracking is enabled by defining SEARCH_FILTER_MINMAX_EN.
module search_result_filter
    import search_pkg::*;
#(
    parameter int DATA_W     = SEARCH_DATA_W,
    parameter int LOG2_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] res_in,
    input  logic              res_stb,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out
);
    localparam int SUM_W = DATA_W + LOG2_DEPTH;

    logic [SUM_W-1:0]  sum;
    logic              upd;
    logic [DATA_W-1:0] avg_out_reg;
    logic              avg_valid_reg;
    logic              overrun_reg;

    search_avg_window #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .res_in  (res_in),
        .res_stb (res_stb),
        .sum     (sum),
        .upd     (upd)
    );

    // A load always wins; it only counts as an overrun when the old value was still unaccepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_out_reg   <= '0;
            avg_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (upd) begin
            avg_out_reg   <= DATA_W'(sum >> LOG2_DEPTH);
            avg_valid_reg <= 1'b1;
            if (avg_valid_reg && !avg_ready) begin
                overrun_reg <= 1'b1;
            end
        end else if (avg_valid_reg && avg_ready) begin
            avg_valid_reg <= 1'b0;
        end
    end

    assign avg_out   = avg_out_reg;
    assign avg_valid = avg_valid_reg;
    assign overrun   = overrun_reg;

`ifdef SEARCH_FILTER_MINMAX_EN
    logic [DATA_W-1:0] min_reg;
    logic [DATA_W-1:0] max_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            min_reg <= '1;
            max_reg <= '0;
        end else if (res_stb) begin
            if (res_in < min_reg) min_reg <= res_in;
            if (res_in > max_reg) max_reg <= res_in;
        end
    end

    assign min_out = min_reg;
    assign max_out = max_reg;
`else
    assign min_out = '1;
    assign max_out = '0;
`endif
endmodule

// File: doc/search_result_filter.md
Name: search_result_filter

Overview:
- Downstream consumer of the 8-bit binary-search converter result; one new result per 8-cycle conversion frame.
- Keeps a sliding window of the last 2^LOG2_DEPTH results and produces their truncated mean.
- Output uses a valid/ready handshake with a sticky overrun flag, so a slow consumer can be detected.
- Sits between the search stage and any display/log logic.

Parameters:
- DATA_W, 8, width of each converter result and of avg_out.
- LOG2_DEPTH, 2, log2 of window length. Legal range 1..4, so the window is 2 to 16 samples.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- res_in  in  DATA_W  converter result; valid only while res_stb=1.
- res_stb  in  1  one-cycle strobe marking a new result. Nominally one per 8 cycles; back-to-back strobes must also work.
- avg_out  out  DATA_W  windowed mean.
- avg_valid  out  1  avg_out holds an unconsumed value.
- avg_ready  in  1  consumer accepts avg_out while avg_valid=1.
- overrun  out  1  sticky flag: an unconsumed average was overwritten.
- min_out  out  DATA_W  minimum result since reset; only with MINMAX_EN.
- max_out  out  DATA_W  maximum result since reset; only with MINMAX_EN.

Behaviour:
- Reset values (rst=1 at an edge):
  - ring buffer entries, wr_ptr, sum and fill all clear to 0;
  - avg_out=0, avg_valid=0, overrun=0;
  - min_out=all-ones, max_out=0.
  - Reset overrides every other event in the same cycle, including a strobe or a pending handshake.
- Storage:
  - Ring buffer of DEPTH=2^LOG2_DEPTH entries, each DATA_W wide.
  - wr_ptr is LOG2_DEPTH bits and wraps naturally from DEPTH-1 to 0.
  - Running sum is DATA_W+LOG2_DEPTH bits; it can never overflow.
- Stage 1, at the edge where res_stb=1:
  - buf[wr_ptr] <= res_in;
  - sum <= sum + res_in - buf[wr_ptr], where buf[wr_ptr] is the old entry (0 during warm-up because of reset);
  - wr_ptr increments;
  - fill increments and saturates at DEPTH.
  - Set internal upd=1 if the fill value after the increment equals DEPTH; otherwise upd=0.
- Stage 2, at the next edge when upd=1:
  - avg_out <= sum >> LOG2_DEPTH (truncating);
  - avg_valid <= 1.
  - Latency: strobe in cycle t gives avg_valid=1 in cycle t+2.
- Warm-up: no average is produced until DEPTH results have been received since reset.
- Handshake:
  - A transfer occurs at any edge where avg_valid=1 and avg_ready=1.
  - On a transfer with no simultaneous load, avg_valid <= 0.
  - If a load and a transfer happen at the same edge, the new value is loaded, avg_valid stays 1, and overrun is not set.
  - If a load happens while avg_valid=1 and avg_ready=0, the new value overwrites avg_out (latest wins) and overrun <= 1.
  - overrun clears only on reset.
  - avg_out must stay stable while avg_valid=1 and no load occurs.
- avg_ready is ignored while avg_valid=0.
- Back-to-back strobes: each one updates the sum. Stage 2 loads the mean every cycle after the window is full.

Optional Feature:
- Macro: SEARCH_FILTER_MINMAX_EN.
- Defined:
  - at every strobe, min_out <= min(min_out, res_in) and max_out <= max(max_out, res_in);
  - both update in the same cycle as stage 1, warm-up included.
- Undefined:
  - min_out and max_out ports are still present, tied to all-ones and 0 respectively;
  - no comparators are built.

Decomposition:
- Shared package search_pkg holds:
  - SEARCH_DATA_W=8;
  - SEARCH_FRAME_LEN=8, the cycles per conversion;
  - a typedef search_res_t for a DATA_W-bit logic vector.
- One sub-module, search_avg_window: ring buffer, wr_ptr, fill counter and running sum.
  - Outputs: sum and upd.
  - The top level holds stage 2, the handshake, overrun and min/max.

Test Plan (DEPTH=4):
- Strobes with 10,20,30,40, avg_ready=1 → single avg_valid pulse two cycles after the 4th strobe, avg_out=25; no valid pulse after strobes 1-3.
- Continue with a strobe of 50 → avg_out=35. Then a strobe of 0 → avg_out=30, confirming the oldest entry is evicted and the pointer wraps.
- Four strobes of 255 → avg_out=255 (sum=1020 with no wrap). Four strobes of 3,0,0,0 → avg_out=0 (truncation).
- avg_ready held 0, window full, two strobes 8 cycles apart → overrun=1, avg_out equals the second mean, avg_valid=1. Raise avg_ready for one cycle → avg_valid=0 while overrun stays 1.
- Two strobes, then rst for one cycle, then four strobes of 8 → no output until the 4th post-reset strobe, then avg_out=8 and overrun=0.
- With SEARCH_FILTER_MINMAX_EN: strobes of 100,7,200,50 → min_out=7, max_out=200. After rst → min_out=255, max_out=0.
